// File: rtl/csr_exec_seq.sv
// csr_exec_seq: sequences one CSR-class instruction (CSRRW/CSRRS/CSRRC,
// ECALL, MRET) into read and dual-port write cycles for the CSR file,
// returning the old CSR value for rd and a PC redirect for traps/returns.
module csr_exec_seq #(
    parameter logic [31:0] ECALL_CAUSE = 32'd11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [2:0]  op,
    input  logic [11:0] csr_addr,
    input  logic [31:0] rs1_val,
    input  logic        rs1_zero,
    input  logic [31:0] pc,
    output logic        busy,
    output logic        done,
    output logic        illegal,
    output logic [31:0] rd_val,
    output logic        redirect,
    output logic [31:0] next_pc,
    output logic        csr_wen,
    output logic [11:0] csr_waddr1,
    output logic [31:0] csr_wdata1,
    output logic [11:0] csr_waddr2,
    output logic [31:0] csr_wdata2,
    output logic [11:0] csr_raddr,
    input  logic [31:0] csr_rdata
);

    localparam logic [2:0] OP_CSRRW = 3'd0;
    localparam logic [2:0] OP_CSRRS = 3'd1;
    localparam logic [2:0] OP_CSRRC = 3'd2;
    localparam logic [2:0] OP_ECALL = 3'd3;
    localparam logic [2:0] OP_MRET  = 3'd4;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Only the four machine-mode CSRs below exist in this CSR file.
    function automatic logic csr_supported(input logic [11:0] addr);
        logic hit;
        case (addr)
            CSR_MSTATUS, CSR_MTVEC, CSR_MEPC, CSR_MCAUSE: hit = 1'b1;
            default:                                      hit = 1'b0;
        endcase
        return hit;
    endfunction

    state_t      state_r;
    logic [2:0]  op_r;
    logic [11:0] addr_r;
    logic [31:0] rs1_r;
    logic        rs1_zero_r;
    logic [31:0] pc_r;
    logic [31:0] old_r;
    logic        illegal_r;
    logic [31:0] rd_val_r;
    logic [31:0] next_pc_r;

    logic        req_illegal_s;
    logic        write_skip_s;
    logic        done_s;
    logic        redirect_s;
    logic        wen_s;
    logic [11:0] waddr1_s;
    logic [31:0] wdata1_s;
    logic [11:0] waddr2_s;
    logic [31:0] wdata2_s;
    logic [11:0] raddr_s;

    assign req_illegal_s = (op > OP_MRET) ||
                           ((op <= OP_CSRRC) && !csr_supported(csr_addr));

    // Set/clear with rs1 = x0 must not write, although WRITE is still visited.
    assign write_skip_s = ((op_r == OP_CSRRS) || (op_r == OP_CSRRC)) && rs1_zero_r;

    // Sequencer state, latched request fields and held result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= S_IDLE;
            op_r       <= 3'd0;
            addr_r     <= 12'd0;
            rs1_r      <= 32'd0;
            rs1_zero_r <= 1'b0;
            pc_r       <= 32'd0;
            old_r      <= 32'd0;
            illegal_r  <= 1'b0;
            rd_val_r   <= 32'd0;
            next_pc_r  <= 32'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (req) begin
                        op_r       <= op;
                        addr_r     <= csr_addr;
                        rs1_r      <= rs1_val;
                        rs1_zero_r <= rs1_zero;
                        pc_r       <= pc;
                        if (req_illegal_s) begin
                            state_r   <= S_DONE;
                            illegal_r <= 1'b1;
                            rd_val_r  <= 32'd0;
                        end else begin
                            state_r <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    old_r <= csr_rdata;
                    if (op_r == OP_MRET) begin
                        state_r   <= S_DONE;
                        illegal_r <= 1'b0;
                        rd_val_r  <= 32'd0;
                        next_pc_r <= csr_rdata;
                    end else begin
                        state_r <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    state_r   <= S_DONE;
                    illegal_r <= 1'b0;
                    if (op_r == OP_ECALL) begin
                        rd_val_r  <= 32'd0;
                        next_pc_r <= old_r;
                    end else begin
                        rd_val_r <= old_r;
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    // CSR file strobes and handshake outputs decoded from state and latched fields.
    always_comb begin
        done_s     = 1'b0;
        redirect_s = 1'b0;
        wen_s      = 1'b0;
        waddr1_s   = 12'h000;
        wdata1_s   = 32'd0;
        waddr2_s   = 12'h000;
        wdata2_s   = 32'd0;
        raddr_s    = 12'h000;
        case (state_r)
            S_READ: begin
                case (op_r)
                    OP_CSRRW, OP_CSRRS, OP_CSRRC: raddr_s = addr_r;
                    OP_ECALL:                     raddr_s = CSR_MTVEC;
                    OP_MRET:                      raddr_s = CSR_MEPC;
                    default:                      raddr_s = 12'h000;
                endcase
            end
            S_WRITE: begin
                if (!write_skip_s) begin
                    case (op_r)
                        OP_CSRRW: begin
                            wen_s    = 1'b1;
                            waddr1_s = addr_r;
                            wdata1_s = rs1_r;
                            waddr2_s = addr_r;
                            wdata2_s = rs1_r;
                        end
                        OP_CSRRS: begin
                            wen_s    = 1'b1;
                            waddr1_s = addr_r;
                            wdata1_s = old_r | rs1_r;
                            waddr2_s = addr_r;
                            wdata2_s = old_r | rs1_r;
                        end
                        OP_CSRRC: begin
                            wen_s    = 1'b1;
                            waddr1_s = addr_r;
                            wdata1_s = old_r & ~rs1_r;
                            waddr2_s = addr_r;
                            wdata2_s = old_r & ~rs1_r;
                        end
                        OP_ECALL: begin
                            wen_s    = 1'b1;
                            waddr1_s = CSR_MEPC;
                            wdata1_s = pc_r;
                            waddr2_s = CSR_MCAUSE;
                            wdata2_s = ECALL_CAUSE;
                        end
                        default: begin
                            wen_s = 1'b0;
                        end
                    endcase
                end else begin
                    wen_s = 1'b0;
                end
            end
            S_DONE: begin
                done_s     = 1'b1;
                redirect_s = !illegal_r && ((op_r == OP_ECALL) || (op_r == OP_MRET));
            end
            default: begin
                done_s = 1'b0;
            end
        endcase
    end

    assign busy       = (state_r != S_IDLE);
    assign done       = done_s;
    assign redirect   = redirect_s;
    assign illegal    = illegal_r;
    assign rd_val     = rd_val_r;
    assign next_pc    = next_pc_r;
    assign csr_wen    = wen_s;
    assign csr_waddr1 = waddr1_s;
    assign csr_wdata1 = wdata1_s;
    assign csr_waddr2 = waddr2_s;
    assign csr_wdata2 = wdata2_s;
    assign csr_raddr  = raddr_s;

endmodule
